// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions: checker FSM states, seed and the per-bit LFSR step.
// The step function is also used by the link's CRC-8 generator.
package crc8_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        CHECK   = 2'd2,
        REPORT  = 2'd3
    } crc8_state_t;

    localparam logic [7:0] CRC8_SEED = 8'h00;

    // One data bit into the remainder, LSB-side feedback.
    function automatic logic [7:0] crc8_next(input logic [7:0] r, input logic d);
        logic fb;
        fb = d ^ r[0];
        return {fb, r[7] ^ fb, r[6:4], r[3] ^ fb, r[2:1]};
    endfunction

endpackage

// File: rtl/crc8_lfsr.sv
// Purpose: 8-bit CRC remainder register; absorbs data bits or shifts out LSB first.
// Latency: remainder updates on the edge after clr/upd_en/shift_en.
// Backpressure: none; priority is clr > upd_en > shift_en.
module crc8_lfsr
    import crc8_pkg::*;
(
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       upd_en,
    input  logic       shift_en,
    input  logic       din,
    output logic       r0,
    output logic [7:0] rem
);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rem <= CRC8_SEED;
        end else if (clr) begin
            rem <= CRC8_SEED;
        end else if (upd_en) begin
            rem <= crc8_next(rem, din);
        end else if (shift_en) begin
            rem <= {1'b0, rem[7:1]};
        end
    end

    assign r0 = rem[0];

endmodule

// File: rtl/crc8_checker.sv
// Purpose: serial CRC-8 frame checker; Err_Cnt exists only with CRC8_CHK_ERR_CNT_EN.
// Latency: Done/Pass/Len_Err one cycle after the 8th CRC bit or the error condition.
// Backpressure: none; bits arriving while Done=1 are dropped.
module crc8_checker
    import crc8_pkg::*;
#(
    parameter int CRC_W  = 8,
    parameter int TO_CYC = 16
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       DATA,
    input  logic       Active,
    input  logic       CRC_IN,
    input  logic       CRC_Valid,
    output logic       Done,
    output logic       Pass,
    output logic       Len_Err,
    output logic [7:0] Err_Cnt
);

    localparam logic [3:0] LAST_BIT = 4'(CRC_W);
    localparam logic [4:0] TO_LIM   = 5'(TO_CYC);

    crc8_state_t state;
    logic [3:0]  cnt;
    logic [4:0]  to_cnt;
    logic        mismatch;

    logic        lfsr_r0;
    logic [7:0]  lfsr_rem;
    logic        unused_rem;
    logic        upd_en, shift_en, clr;
    logic        mis_nx;
    logic [3:0]  cnt_nx;
    logic [4:0]  to_nx;
    logic        rpt, rpt_len, rpt_mis;

    // Only bit 0 of the remainder is consumed here; the full value serves the generator side.
    assign unused_rem = ^lfsr_rem;

    crc8_lfsr u_lfsr (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .clr      (clr),
        .upd_en   (upd_en),
        .shift_en (shift_en),
        .din      (DATA),
        .r0       (lfsr_r0),
        .rem      (lfsr_rem)
    );

    always_comb begin
        upd_en   = Active && (state == IDLE || state == RECEIVE);
        shift_en = CRC_Valid && !Active && (state == RECEIVE || state == CHECK);
        clr      = (state == REPORT);
        mis_nx   = mismatch | (CRC_IN != lfsr_r0);
        cnt_nx   = cnt + 4'd1;
        to_nx    = (to_cnt == 5'h1F) ? to_cnt : to_cnt + 5'd1;

        rpt      = 1'b0;
        rpt_len  = 1'b0;
        rpt_mis  = mismatch;
        if (state == CHECK) begin
            if (Active) begin
                rpt     = 1'b1;
                rpt_len = 1'b1;
            end else if (CRC_Valid) begin
                if (cnt_nx == LAST_BIT) begin
                    rpt     = 1'b1;
                    rpt_mis = mis_nx;
                end
            end else if (cnt != 4'd0 || to_nx == TO_LIM) begin
                // Timeout counts idle CHECK cycles only, not the cycle Active fell.
                rpt     = 1'b1;
                rpt_len = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            to_cnt   <= 5'd0;
            mismatch <= 1'b0;
            Done     <= 1'b0;
            Pass     <= 1'b0;
            Len_Err  <= 1'b0;
        end else begin
            Done <= rpt;
            if (rpt) begin
                Pass    <= !rpt_mis && !rpt_len;
                Len_Err <= rpt_len;
            end
            case (state)
                IDLE: begin
                    cnt      <= 4'd0;
                    to_cnt   <= 5'd0;
                    mismatch <= 1'b0;
                    if (Active) state <= RECEIVE;
                end
                RECEIVE: begin
                    if (!Active) begin
                        state  <= CHECK;
                        to_cnt <= 5'd0;
                        if (CRC_Valid) begin
                            mismatch <= mis_nx;
                            cnt      <= cnt_nx;
                        end
                    end
                end
                CHECK: begin
                    if (rpt) begin
                        state <= REPORT;
                    end else if (CRC_Valid) begin
                        mismatch <= mis_nx;
                        cnt      <= cnt_nx;
                    end else begin
                        to_cnt <= to_nx;
                    end
                end
                REPORT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CRC8_CHK_ERR_CNT_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            Err_Cnt <= 8'h00;
        end else if (rpt && (rpt_mis || rpt_len) && Err_Cnt != 8'hFF) begin
            Err_Cnt <= Err_Cnt + 8'h01;
        end
    end
`else
    assign Err_Cnt = 8'h00;
`endif

endmodule

// File: tb/tb_crc8_checker.sv
// Directed and randomized frames against a bit-serial CRC model; reports one summary line.
module tb_crc8_checker;

    localparam int TO_CYC = 16;
`ifdef CRC8_CHK_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       DATA, Active, CRC_IN, CRC_Valid;
    logic       Done, Pass, Len_Err;
    logic [7:0] Err_Cnt;

    int checks = 0;
    int errors = 0;
    int err_model = 0;

    crc8_checker #(.CRC_W(8), .TO_CYC(TO_CYC)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .DATA      (DATA),
        .Active    (Active),
        .CRC_IN    (CRC_IN),
        .CRC_Valid (CRC_Valid),
        .Done      (Done),
        .Pass      (Pass),
        .Len_Err   (Len_Err),
        .Err_Cnt   (Err_Cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Reflected CRC-8: shift right, xor 0xC4 when (data bit ^ remainder LSB) is 1.
    function automatic logic [7:0] model_crc(input logic [63:0] d, input int n);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < n; i++)
            r = (r >> 1) ^ ((d[i] ^ r[0]) ? 8'hC4 : 8'h00);
        return r;
    endfunction

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic a, input logic d, input logic v, input logic c);
        @(posedge CLK);
        #1;
        Active = a; DATA = d; CRC_Valid = v; CRC_IN = c;
    endtask

    task automatic send_frame(input logic [63:0] d, input int n, input logic [7:0] crc,
                              input int ncrc, input int gap, input bit junk);
        for (int i = 0; i < n; i++) drive(1'b1, d[i], junk & $urandom_range(0, 1), 1'b1);
        for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < ncrc; i++) drive(1'b0, 1'b0, 1'b1, crc[i]);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_report(input int exp_lat, input logic exp_pass, input logic exp_len,
                                 input string tag);
        int lat;
        lat = 0;
        forever begin
            @(negedge CLK);
            if (Done || lat > 60) break;
            lat++;
        end
        check(lat, exp_lat, {tag, "_done_latency"});
        if (!exp_pass && err_model < 255) err_model++;
        check(Pass, exp_pass, {tag, "_pass"});
        check(Len_Err, exp_len, {tag, "_len_err"});
        check(Err_Cnt, CNT_EN ? err_model : 0, {tag, "_err_cnt"});
    endtask

    initial begin
        logic [63:0] d;
        logic [7:0]  c;
        int          n, gap, seen;

        rst_n = 1'b0;
        Active = 1'b0; DATA = 1'b0; CRC_Valid = 1'b0; CRC_IN = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check(Done, 0, "reset_done");
        check(Pass, 0, "reset_pass");
        check(Len_Err, 0, "reset_len_err");
        check(Err_Cnt, 0, "reset_err_cnt");
        rst_n = 1'b1;

        // Eight zero data bits, all-zero CRC.
        send_frame(64'h0, 8, 8'h00, 8, 0, 1'b0);
        expect_report(0, 1'b1, 1'b0, "zeros");

        // Single 1 bit gives remainder 0xC4, sent 0,0,1,0,0,0,1,1.
        send_frame(64'h1, 1, 8'hC4, 8, 0, 1'b0);
        expect_report(0, 1'b1, 1'b0, "one_bit");
        repeat (3) @(negedge CLK);
        check(Done, 0, "done_single_pulse");
        check(Pass, 1, "pass_held");

        send_frame(64'h1, 1, 8'hC4 ^ 8'h04, 8, 0, 1'b0);
        expect_report(0, 1'b0, 1'b0, "crc_bit3_flip");

        // CRC_Valid drops after 5 bits: error seen in the drop cycle.
        send_frame(64'h1, 1, 8'hC4, 5, 0, 1'b0);
        expect_report(1, 1'b0, 1'b1, "short_crc");

        // No CRC at all: one transition cycle then TO_CYC idle CHECK cycles.
        send_frame(64'h5, 3, 8'h00, 0, 0, 1'b0);
        expect_report(TO_CYC + 1, 1'b0, 1'b1, "timeout");

        // CRC_Valid while idle produces no report.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, i[0]);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (Done) seen++;
        end
        check(seen, 0, "idle_crc_ignored");

        // Active returning during CHECK.
        d = 64'h6;
        send_frame(d, 3, 8'h00, 0, 2, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_report(0, 1'b0, 1'b1, "active_in_check");

        // Loopback: random lengths, gaps, and CRC_Valid noise during data.
        for (int f = 0; f < 100; f++) begin
            d   = {$urandom, $urandom};
            n   = $urandom_range(1, 64);
            gap = $urandom_range(0, 3);
            send_frame(d, n, model_crc(d, n), 8, gap, 1'b1);
            expect_report(0, 1'b1, 1'b0, "loopback");
        end

        // Reset mid-CRC discards the frame.
        d = {$urandom, $urandom};
        for (int i = 0; i < 10; i++) drive(1'b1, d[i], 1'b0, 1'b0);
        c = model_crc(d, 10);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, c[i]);
        #1 rst_n = 1'b0;
        err_model = 0;
        @(negedge CLK);
        check(Done, 0, "midreset_done");
        check(Pass, 0, "midreset_pass");
        check(Len_Err, 0, "midreset_len_err");
        check(Err_Cnt, 0, "midreset_err_cnt");
        for (int i = 3; i < 8; i++) drive(1'b0, 1'b0, 1'b1, c[i]);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (Done) seen++;
        end
        check(seen, 0, "midreset_no_done");
        d = {$urandom, $urandom};
        send_frame(d, 17, model_crc(d, 17), 8, 1, 1'b0);
        expect_report(0, 1'b1, 1'b0, "after_reset");

        // Corrupted frames drive the error counter into saturation.
        for (int f = 0; f < 300; f++) begin
            d = {$urandom, $urandom};
            n = $urandom_range(1, 8);
            c = model_crc(d, n) ^ (8'h01 << $urandom_range(0, 7));
            send_frame(d, n, c, 8, 0, 1'b0);
            expect_report(0, 1'b0, 1'b0, "corrupt");
        end
        check(Err_Cnt, CNT_EN ? 8'hFF : 8'h00, "err_cnt_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc8_checker.md
# crc8_checker

Serial CRC-8 checker at the receive end of the team's serial CRC link. It consumes a data bit stream qualified by `Active`, then the 8 CRC bits qualified by `CRC_Valid`, LSB of the remainder first. At the end of each frame it reports pass/fail. It pairs with the existing CRC-8 generator: the generator's `DATA`/`Active` stream and `CRC`/`Valid` outputs connect directly to this block's inputs.

## Interface
Parameters:
- `CRC_W`, 8: remainder width. Fixed at 8; the polynomial taps are hard-coded.
- `TO_CYC`, 16: idle cycles allowed between end of data and first CRC bit.

Ports:
- `CLK` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `DATA` in 1: serial data bit, valid when `Active`=1.
- `Active` in 1: data-phase qualifier.
- `CRC_IN` in 1: serial CRC bit, valid when `CRC_Valid`=1.
- `CRC_Valid` in 1: CRC-phase qualifier.
- `Done` out 1: one-cycle pulse at end of frame.
- `Pass` out 1: frame CRC matched and length was correct. Held until the next `Done`.
- `Len_Err` out 1: framing/length error. Held until the next `Done`.
- `Err_Cnt` out 8: saturating count of failed frames. Only present with the macro; see Configuration.

## Operation
- LFSR update per data bit (`r` = 8-bit remainder):
  - FB = `DATA` ^ r[0]
  - r_next = {FB, r[7]^FB, r[6:4], r[3]^FB, r[2:1]}
  - Seed is 8'h00.
- States:
  - IDLE: r=0, bit count=0, mismatch=0, len_err=0. `Active`=1 → apply the update with `DATA` in the same cycle, go to RECEIVE.
  - RECEIVE: `Active`=1 → update. `Active`=0 → go to CHECK and start the timeout counter. If `CRC_Valid`=1 in that same cycle, that bit is checked immediately.
  - CHECK, on a `CRC_Valid`=1 cycle:
    - mismatch |= (`CRC_IN` != r[0])
    - r ← r>>1 (zero fill)
    - count++
    - count reaches 8 → REPORT.
  - CHECK, exit on error (each → REPORT with len_err=1):
    - `CRC_Valid` drops after 1–7 bits.
    - Timeout reaches `TO_CYC` with no CRC bit received.
    - `Active`=1 while in CHECK.
  - REPORT: one cycle.
    - `Done`=1.
    - `Pass` ← !mismatch & !len_err.
    - `Len_Err` ← len_err.
    - Next state is IDLE.
- `Active` and `CRC_Valid` both high in RECEIVE: `Active` wins. The CRC bit is ignored.
- `CRC_Valid`=1 while in IDLE: ignored, no report.
- A frame always has ≥1 data bit; there are no zero-length frames.

## Timing
- All outputs are registered.
- Reset values: `Done`=0, `Pass`=0, `Len_Err`=0, `Err_Cnt`=0. The FSM resets to IDLE and r resets to 0.
- `Done` is asserted in the cycle after the 8th `CRC_Valid` sample, or in the cycle after the error condition is detected.
- `Pass` and `Len_Err` update on the same edge that raises `Done`.
- Back-to-back frames: `Active` may rise in the cycle `Done`=1. That bit is lost, so the sender must leave at least one idle cycle after the last CRC bit. The existing generator always does.
- Reset mid-frame: the frame is discarded and no `Done` is issued.
- The timeout counter is 5 bits wide, cleared on entry to CHECK, and saturates.

## Configuration
- `CRC8_CHK_ERR_CNT_EN` defined:
  - `Err_Cnt` increments on every `Done` with `Pass`=0.
  - Saturates at 8'hFF.
  - Cleared only by reset.
- Not defined: the counter logic is absent and `Err_Cnt` is tied to 8'h00.

## Structure
- Shared package `crc8_pkg`:
  - State enum (IDLE, RECEIVE, CHECK, REPORT).
  - `CRC8_SEED` = 8'h00.
  - The LFSR next-state function, so it is shared with the generator.
- One sub-module, `crc8_lfsr`:
  - Holds the 8-bit remainder.
  - Inputs: clear, update enable, shift-out enable, data bit.
  - Outputs: r[0] and the full remainder.

## Test plan
- Data 8'h00 (8 zero bits), then CRC bits 0×8 → `Done` pulse, `Pass`=1, `Len_Err`=0.
- Single data bit 1 (remainder 8'hC4), then CRC bits 0,0,1,0,0,0,1,1 → `Pass`=1. Same frame with the 3rd CRC bit flipped → `Pass`=0, `Len_Err`=0, `Err_Cnt`=1 (macro on).
- Single data bit 1, `CRC_Valid` dropped after 5 bits → `Done` on the next cycle, `Pass`=0, `Len_Err`=1.
- Data ends and `CRC_Valid` never rises → `Done` after 16 idle cycles, `Len_Err`=1.
- Loopback with the CRC-8 generator: 100 random frames of 1–64 bits → every frame `Pass`=1. `rst_n` pulsed mid-frame → no `Done`, all outputs 0, and the next frame passes.
- 300 corrupted frames with macro on → `Err_Cnt` saturates at 8'hFF. With macro off → `Err_Cnt` stays 8'h00.
